ps2_command_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard.
- Complements the existing receive path, and shares the same PS2_CLK/PS2_DAT open-drain lines.
- The top level gates the lines as `PS2_x = oe ? 1'b0 : 1'bz` and holds the receiver idle while busy=1.
- Handles clock inhibit, request-to-send, bit shifting on device clock edges, odd parity, stop bit, device ACK and timeouts.

---
 rtl/ps2_command_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_command_tx #(
    parameter int CLK_INHIBIT_CYCLES   = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_sent,
    output logic       error_timeout,
    output logic       error_no_ack
);
    localparam int MAX_A      = (CLK_INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? CLK_INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > BIT_TIMEOUT_CYCLES) ? MAX_A : BIT_TIMEOUT_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST   = CW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(BIT_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_START,
        S_SHIFT,
        S_WAIT_ACK,
        S_WAIT_RELEASE,
        S_ERROR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [8:0]    frame, frame_n;
    logic          clk_oe_n, dat_oe_n, sent_n, timeout_n, no_ack_n;

    // Synchronizer flops idle high so leaving reset never fakes a falling edge
    logic clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
    logic clk_fall;

    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta      <= 1'b1;
            clk_sync      <= 1'b1;
            clk_prev      <= 1'b1;
            dat_meta      <= 1'b1;
            dat_sync      <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            frame         <= '0;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            busy          <= 1'b0;
            command_sent  <= 1'b0;
            error_timeout <= 1'b0;
            error_no_ack  <= 1'b0;
        end else begin
            clk_meta      <= ps2_clk_in;
            clk_sync      <= clk_meta;
            clk_prev      <= clk_sync;
            dat_meta      <= ps2_dat_in;
            dat_sync      <= dat_meta;
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            frame         <= frame_n;
            ps2_clk_oe    <= clk_oe_n;
            ps2_dat_oe    <= dat_oe_n;
            busy          <= (state_n != S_IDLE);
            command_sent  <= sent_n;
            error_timeout <= timeout_n;
            error_no_ack  <= no_ack_n;
        end
    end

    // Outputs are computed for the next state and registered alongside it
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        frame_n   = frame;
        clk_oe_n  = 1'b0;
        dat_oe_n  = 1'b0;
        sent_n    = 1'b0;
        timeout_n = 1'b0;
        no_ack_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (send_command) begin
                    frame_n   = {~^command, command};
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_n = 1'b1;
                if (cnt == INHIBIT_LAST) begin
                    cnt_n    = '0;
                    dat_oe_n = 1'b1;
                    state_n  = S_REQ;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_REQ: begin
                dat_oe_n = 1'b1;
                cnt_n    = '0;
                state_n  = S_WAIT_START;
            end
            S_WAIT_START: begin
                dat_oe_n = 1'b1;
                if (clk_fall) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    dat_oe_n  = ~frame[0];
                    state_n   = S_SHIFT;
                end else if (cnt == START_LAST) begin
                    dat_oe_n  = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_ERROR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                dat_oe_n = ps2_dat_oe;
                if (clk_fall) begin
                    cnt_n = '0;
                    // Parity is on the line when bit_idx reaches 8; the stop bit is a release
                    if (bit_idx == 4'd8) begin
                        dat_oe_n = 1'b0;
                        state_n  = S_WAIT_ACK;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        dat_oe_n  = ~frame[1];
                        frame_n   = {1'b1, frame[8:1]};
                    end
                end else if (cnt == BIT_LAST) begin
                    dat_oe_n  = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_ERROR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_ACK: begin
                if (clk_fall) begin
                    cnt_n = '0;
                    if (dat_sync) begin
                        no_ack_n = 1'b1;
                        state_n  = S_ERROR;
                    end else begin
                        state_n = S_WAIT_RELEASE;
                    end
                end else if (cnt == BIT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = S_ERROR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_RELEASE: begin
                if (clk_sync && dat_sync) begin
                    sent_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt == BIT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = S_ERROR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_ERROR: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - randomized bench with PS/2 device model for ps2_command_tx
module tb_ps2_command_tx;
    localparam int INH = 20;
    localparam int STO = 100;
    localparam int BTO = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, command_sent, error_timeout, error_no_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_sent = 0, n_to = 0, n_nack = 0;
    int clk_run = 0, last_clk_run = 0, last_dat_off = -1;
    int fall_cyc = 0, to_cyc = 0;
    int half = 8;
    logic prev_busy = 1'b0, prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

    // Open-drain bus: either side can pull a line low
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_command_tx #(
        .CLK_INHIBIT_CYCLES  (INH),
        .START_TIMEOUT_CYCLES(STO),
        .BIT_TIMEOUT_CYCLES  (BTO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .command      (command),
        .send_command (send_command),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .ps2_clk_oe   (ps2_clk_oe),
        .ps2_dat_oe   (ps2_dat_oe),
        .busy         (busy),
        .command_sent (command_sent),
        .error_timeout(error_timeout),
        .error_no_ack (error_no_ack)
    );

    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Every cycle advance goes through here so the per-cycle compare never misses one
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (command_sent === 1'b1) n_sent++;
        if (error_timeout === 1'b1) begin
            n_to++;
            to_cyc = cyc;
        end
        if (error_no_ack === 1'b1) n_nack++;
        if (reset === 1'b0) begin
            check("one_status", ($countones({command_sent, error_timeout, error_no_ack}) <= 1), 1);
            if (busy === 1'b0) check("idle_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
            if (command_sent === 1'b1) check("sent_busy_fall", {busy, prev_busy}, 2'b01);
            if (error_timeout === 1'b1 || error_no_ack === 1'b1)
                check("error_lines", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b100);
            if (ps2_clk_oe === 1'b1) clk_run = (prev_clk_oe === 1'b1) ? clk_run + 1 : 1;
            if (ps2_dat_oe === 1'b1 && prev_dat_oe === 1'b0 && ps2_clk_oe === 1'b1) last_dat_off = clk_run - 1;
            if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) begin
                last_clk_run = clk_run;
                fall_cyc = cyc;
            end
        end
        prev_busy   = busy;
        prev_clk_oe = ps2_clk_oe;
        prev_dat_oe = ps2_dat_oe;
    endtask

    task automatic send(input logic [7:0] c);
        command = c;
        send_command = 1'b1;
        tick();
        send_command = 1'b0;
    endtask

    // Keyboard side: wait for request-to-send, clock out edges, read DAT while clock is low
    task automatic device_run(input int edges, input bit ack, input int poke_edge,
                              output logic [9:0] bits, output bit ok);
        int t;
        bits = '0;
        ok = 1'b1;
        t = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1 && busy === 1'b1)) begin
            tick();
            t++;
            if (t > 500) begin
                ok = 1'b0;
                return;
            end
        end
        for (int e = 1; e <= edges; e++) begin
            repeat (half) tick();
            if (e == 11) dev_dat = ~ack;
            dev_clk = 1'b0;
            if (e == poke_edge) begin
                command = command ^ 8'hFF;
                send_command = 1'b1;
                tick();
                send_command = 1'b0;
                repeat (half - 1) tick();
            end else begin
                repeat (half) tick();
            end
            if (e <= 10) bits[e-1] = ps2_dat_in;
            dev_clk = 1'b1;
        end
        if (edges == 11) begin
            repeat (half) tick();
            dev_dat = 1'b1;
        end
    endtask

    // kind: 0 ACK, 1 no ACK, 2 device stops after `stop` edges, 3 device never clocks
    task automatic run_txn(input logic [7:0] c, input int kind, input int stop, input int poke_edge, input int lit);
        logic [9:0] bits, exp, mask;
        bit ok;
        int t, b_sent, b_to, b_nack;
        exp = {1'b1, ($countones(c) % 2 == 0) ? 1'b1 : 1'b0, c};
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            tick();
            t++;
        end
        check("idle_before_send", busy, 0);
        b_sent = n_sent;
        b_to   = n_to;
        b_nack = n_nack;
        send(c);
        check("busy_after_accept", busy, 1);
        if (kind != 3) begin
            device_run((kind == 2) ? stop : 11, (kind == 0), poke_edge, bits, ok);
            check("rts_seen", ok, 1);
            mask = (kind == 2) ? 10'((1 << stop) - 1) : 10'h3FF;
            check("frame_bits", bits & mask, exp & mask);
            if (lit >= 0) check("frame_literal", bits, lit);
        end
        t = 0;
        while ((n_sent + n_to + n_nack) == (b_sent + b_to + b_nack) && t < 3000) begin
            tick();
            t++;
        end
        check("status_seen", (t < 3000), 1);
        check("sent_count", n_sent - b_sent, (kind == 0) ? 1 : 0);
        check("timeout_count", n_to - b_to, (kind >= 2) ? 1 : 0);
        check("no_ack_count", n_nack - b_nack, (kind == 1) ? 1 : 0);
        check("inhibit_len", last_clk_run, INH + 1);
        check("req_offset", last_dat_off, INH);
        if (kind == 3)
            check("start_timeout_delay", (to_cyc - fall_cyc >= STO - 2) && (to_cyc - fall_cyc <= STO + 2), 1);
        tick();
        check("released_after", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        bit ok;
        int base, r, kind;

        reset = 1'b1;
        repeat (3) tick();
        check("reset_state", {ps2_clk_oe, ps2_dat_oe, busy, command_sent, error_timeout, error_no_ack}, 0);
        reset = 1'b0;
        tick();

        run_txn(8'hED, 0, 0, 0, 10'h3ED);
        run_txn(8'hF4, 0, 0, 0, 10'h2F4);
        run_txn(8'h5A, 3, 0, 0, -1);
        run_txn(8'hF4, 1, 0, 0, -1);
        run_txn(8'h3C, 0, 0, 3, -1);

        // Reset while the fifth device edge is being handled
        send(8'hA5);
        device_run(4, 1'b0, 0, bits, ok);
        check("rts_seen_reset", ok, 1);
        repeat (half) tick();
        dev_clk = 1'b0;
        repeat (3) tick();
        base = n_sent + n_to + n_nack;
        reset = 1'b1;
        tick();
        check("reset_mid_release", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (400) tick();
        check("reset_no_status", n_sent + n_to + n_nack - base, 0);

        run_txn(8'hFF, 0, 0, 0, 10'h3FF);

        for (int i = 0; i < 12; i++) begin
            half = $urandom_range(6, 12);
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            run_txn(8'($urandom), kind, $urandom_range(1, 10), (r == 0) ? 2 + $urandom_range(0, 6) : 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
